ds1124_chain_driver: RTL and testbench

DS1124_CHAIN_DRIVER -- requirements
Module: ds1124_chain_driver

---
 rtl/ds1124_pkg.sv | 12 +
 rtl/ds1124_tick_gen.sv | 25 ++
 rtl/ds1124_chain_driver.sv | 128 ++++++++++++
 tb/tb_ds1124_chain_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ds1124_pkg.sv
// Shared definitions for the DS1124 daisy-chain serial driver.
package ds1124_pkg;
  localparam int unsigned BITS_PER_DEV = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/ds1124_tick_gen.sv
// Half-phase prescaler: tick marks the last system cycle of each CLK_DIV window.
module ds1124_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));
endmodule

// File: rtl/ds1124_chain_driver.sv
// Serial write/read-back driver for a chain of DS1124 delay lines sharing one enable.
module ds1124_chain_driver
  import ds1124_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_DEV = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_DEV*BITS_PER_DEV-1:0] delay_values,
  input  logic                            en,
  input  logic                            read_delay,
  output logic                            ready,
  output logic                            ds1124_clk,
  output logic                            ds1124_d,
  output logic                            ds1124_e,
  input  logic                            ds1124_q,
  output logic [NUM_DEV*BITS_PER_DEV-1:0] current_delays,
  output logic                            read_valid,
  output logic                            mismatch
);
  localparam int unsigned W  = NUM_DEV * BITS_PER_DEV;
  localparam int unsigned BW = $clog2(W + 1);

  state_t          state;
  logic [W-1:0]    tx;
  logic [W-1:0]    capture;
  logic [W-1:0]    shadow;
  logic [BW-1:0]   bit_cnt;
  logic            is_write;
  logic            phase;
  logic            tick;
  logic            start;

  assign start = (state == IDLE) && ready && (en || read_delay);

  ds1124_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(start),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ready          <= 1'b0;
      ds1124_clk     <= 1'b0;
      ds1124_d       <= 1'b0;
      ds1124_e       <= 1'b0;
      current_delays <= '0;
      read_valid     <= 1'b0;
      mismatch       <= 1'b0;
      tx             <= '0;
      capture        <= '0;
      shadow         <= '0;
      bit_cnt        <= '0;
      is_write       <= 1'b0;
      phase          <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (start) begin
            ready      <= 1'b0;
            ds1124_e   <= 1'b1;
            ds1124_clk <= 1'b0;
            is_write   <= en;
            tx         <= en ? delay_values : shadow;
            if (en) mismatch <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            ds1124_d <= tx[W-1];
            phase    <= 1'b0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!phase) begin
              capture    <= {capture[W-2:0], ds1124_q};
              ds1124_clk <= 1'b1;
              phase      <= 1'b1;
            end else begin
              // Rotating rather than shifting leaves tx intact after W bits,
              // so it doubles as the value to commit into the shadow.
              tx         <= {tx[W-2:0], tx[W-1]};
              ds1124_clk <= 1'b0;
              phase      <= 1'b0;
              if (bit_cnt == BW'(W - 1)) begin
                state <= HOLD;
              end else begin
                bit_cnt  <= bit_cnt + BW'(1);
                ds1124_d <= tx[W-2];
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ds1124_e <= 1'b0;
            ds1124_d <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          ready          <= 1'b1;
          read_valid     <= 1'b1;
          current_delays <= capture;
          if (is_write) begin
            shadow <= tx;
          end else if (capture != shadow) begin
            mismatch <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ds1124_chain_driver.sv
// Directed bench for ds1124_chain_driver with a two-device shift-register chain model.
module tb_ds1124_chain_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] delay_values = '0;
  logic        en = 1'b0;
  logic        read_delay = 1'b0;
  logic        ready;
  logic        ds1124_clk;
  logic        ds1124_d;
  logic        ds1124_e;
  logic        ds1124_q;
  logic [15:0] current_delays;
  logic        read_valid;
  logic        mismatch;

  int tests = 0;
  int fails = 0;

  logic [15:0] chain = 16'h1234;
  logic [15:0] dseq = '0;
  int e_cycles = 0;
  int rises = 0;
  int rv_cnt = 0;
  int idle_bad = 0;

  ds1124_chain_driver #(
    .CLK_DIV(4),
    .NUM_DEV(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .delay_values  (delay_values),
    .en            (en),
    .read_delay    (read_delay),
    .ready         (ready),
    .ds1124_clk    (ds1124_clk),
    .ds1124_d      (ds1124_d),
    .ds1124_e      (ds1124_e),
    .ds1124_q      (ds1124_q),
    .current_delays(current_delays),
    .read_valid    (read_valid),
    .mismatch      (mismatch)
  );

  always #5 clk = ~clk;

  assign ds1124_q = chain[15];

  always @(posedge ds1124_clk) begin
    rises++;
    dseq = {dseq[14:0], ds1124_d};
    if (ds1124_e) chain <= {chain[14:0], ds1124_d};
  end

  always @(negedge clk) begin
    if (ds1124_e) e_cycles++;
    if (read_valid) rv_cnt++;
    if (!rst && !ds1124_e && (ds1124_clk || ds1124_d)) idle_bad++;
  end

  // Runs one request; poke_at>0 pulses en (with 0xFFFF) for one cycle mid-transaction.
  task automatic run_txn(input logic wr, input logic rd, input logic [15:0] val,
                         input int poke_at, output int lat, output logic rdy1, output logic e1);
    @(negedge clk);
    e_cycles = 0; rises = 0; rv_cnt = 0;
    delay_values = val; en = wr; read_delay = rd;
    @(negedge clk);
    en = 1'b0; read_delay = 1'b0;
    lat = 1; rdy1 = ready; e1 = ds1124_e;
    while (!read_valid && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == poke_at) begin
        en = 1'b1; delay_values = 16'hFFFF;
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (ds1124_e !== 1'b0 || ds1124_clk !== 1'b0 || ds1124_d !== 1'b0) begin
      fails++; $display("FAIL reset_pins: e/clk/d=%b%b%b required 000", ds1124_e, ds1124_clk, ds1124_d); end
    tests++; if (ready !== 1'b0 || read_valid !== 1'b0 || mismatch !== 1'b0) begin
      fails++; $display("FAIL reset_flags: ready/rv/mm=%b%b%b required 000", ready, read_valid, mismatch); end
    tests++; if (current_delays !== 16'h0000) begin
      fails++; $display("FAIL reset_cur: got %h required 0000", current_delays); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b required 1", ready); end
  endtask

  task automatic test_write();
    int lat; logic rdy1, e1;
    run_txn(1'b1, 1'b0, 16'hA55A, 0, lat, rdy1, e1);
    tests++; if (rdy1 !== 1'b0 || e1 !== 1'b1) begin
      fails++; $display("FAIL wr_start: ready=%b e=%b required ready=0 e=1", rdy1, e1); end
    tests++; if (lat !== 138) begin
      fails++; $display("FAIL wr_latency: got %0d required 138", lat); end
    @(negedge clk);
    tests++; if (e_cycles !== 136) begin
      fails++; $display("FAIL wr_e_cycles: got %0d required 136", e_cycles); end
    tests++; if (rises !== 16) begin
      fails++; $display("FAIL wr_rises: got %0d required 16", rises); end
    tests++; if (dseq !== 16'hA55A) begin
      fails++; $display("FAIL wr_dseq: got %h required a55a", dseq); end
    tests++; if (rv_cnt !== 1 || read_valid !== 1'b0 || ready !== 1'b1) begin
      fails++; $display("FAIL wr_done: rv_cnt=%0d rv=%b ready=%b required 1 0 1", rv_cnt, read_valid, ready); end
    tests++; if (current_delays !== 16'h1234 || mismatch !== 1'b0) begin
      fails++; $display("FAIL wr_readback: cur=%h mm=%b required 1234 0", current_delays, mismatch); end
    tests++; if (chain !== 16'hA55A) begin
      fails++; $display("FAIL wr_model: got %h required a55a", chain); end
  endtask

  task automatic test_read();
    int lat; logic rdy1, e1;
    run_txn(1'b0, 1'b1, 16'h0000, 0, lat, rdy1, e1);
    tests++; if (lat !== 138) begin
      fails++; $display("FAIL rd_latency: got %0d required 138", lat); end
    @(negedge clk);
    tests++; if (current_delays !== 16'hA55A || mismatch !== 1'b0) begin
      fails++; $display("FAIL rd_value: cur=%h mm=%b required a55a 0", current_delays, mismatch); end
    tests++; if (chain !== 16'hA55A || dseq !== 16'hA55A) begin
      fails++; $display("FAIL rd_restore: model=%h dseq=%h required a55a a55a", chain, dseq); end
  endtask

  task automatic test_mismatch();
    int lat; logic rdy1, e1;
    chain = 16'hA55B;
    run_txn(1'b0, 1'b1, 16'h0000, 0, lat, rdy1, e1);
    @(negedge clk);
    tests++; if (mismatch !== 1'b1 || current_delays !== 16'hA55B) begin
      fails++; $display("FAIL mm_set: mm=%b cur=%h required 1 a55b", mismatch, current_delays); end
    repeat (5) @(negedge clk);
    tests++; if (mismatch !== 1'b1) begin
      fails++; $display("FAIL mm_sticky: got %b required 1", mismatch); end
    run_txn(1'b1, 1'b0, 16'h0F0F, 0, lat, rdy1, e1);
    @(negedge clk);
    tests++; if (mismatch !== 1'b0 || current_delays !== 16'hA55A || chain !== 16'h0F0F) begin
      fails++; $display("FAIL mm_clear: mm=%b cur=%h model=%h required 0 a55a 0f0f", mismatch, current_delays, chain); end
  endtask

  task automatic test_priority_and_ignore();
    int lat; logic rdy1, e1;
    run_txn(1'b1, 1'b1, 16'h3C96, 0, lat, rdy1, e1);
    @(negedge clk);
    tests++; if (chain !== 16'h3C96 || current_delays !== 16'h0F0F) begin
      fails++; $display("FAIL both_write: model=%h cur=%h required 3c96 0f0f", chain, current_delays); end
    run_txn(1'b0, 1'b1, 16'h0000, 50, lat, rdy1, e1);
    tests++; if (lat !== 138) begin
      fails++; $display("FAIL ign_latency: got %0d required 138", lat); end
    repeat (300) @(negedge clk);
    tests++; if (rv_cnt !== 1 || ds1124_e !== 1'b0) begin
      fails++; $display("FAIL ign_single: rv_cnt=%0d e=%b required 1 0", rv_cnt, ds1124_e); end
    tests++; if (chain !== 16'h3C96 || current_delays !== 16'h3C96 || mismatch !== 1'b0) begin
      fails++; $display("FAIL ign_data: model=%h cur=%h mm=%b required 3c96 3c96 0", chain, current_delays, mismatch); end
    tests++; if (idle_bad !== 0) begin
      fails++; $display("FAIL idle_pins: got %0d cycles required 0", idle_bad); end
  endtask

  task automatic test_abort();
    int rv0;
    @(negedge clk);
    rv_cnt = 0; delay_values = 16'h1111; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (ds1124_e !== 1'b1) begin
      fails++; $display("FAIL ab_busy: e=%b required 1", ds1124_e); end
    rv0 = rv_cnt;
    rst = 1'b1;
    #1;
    tests++; if (ds1124_e !== 1'b0 || ds1124_clk !== 1'b0 || ds1124_d !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL ab_pins: e/clk/d/ready=%b%b%b%b required 0000", ds1124_e, ds1124_clk, ds1124_d, ready); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin
      fails++; $display("FAIL ab_ready: got %b required 1", ready); end
    repeat (200) @(negedge clk);
    tests++; if (rv_cnt !== rv0 || ds1124_e !== 1'b0 || current_delays !== 16'h0000 || mismatch !== 1'b0) begin
      fails++; $display("FAIL ab_quiet: rv=%0d e=%b cur=%h mm=%b required %0d 0 0000 0",
                        rv_cnt, ds1124_e, current_delays, mismatch, rv0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_priority_and_ignore();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
